// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode seven-segment driver with hex decode, leading-zero
// suppression, anti-ghost blank time and frame-synchronous double-buffered data.
module seg_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 0
) (
  input  logic                    clkIn,
  input  logic                    rstNIn,
  input  logic                    loadIn,
  input  logic [4*NUM_DIGITS-1:0] digitsIn,
  input  logic [NUM_DIGITS-1:0]   dpIn,
  input  logic [NUM_DIGITS-1:0]   blankIn,
  input  logic                    lzsIn,
  output logic [6:0]              segOut,
  output logic                    decimalOut,
  output logic [NUM_DIGITS-1:0]   anodeOut,
  output logic                    frameOut,
  output logic                    pendingOut
);

  localparam int CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DIGITS - 1);
  localparam logic [CNTW-1:0] BLANK_END = CNTW'(BLANK_CYCLES);

  logic [CNTW-1:0]         cnt;
  logic [IDXW-1:0]         idx;
  logic                    slotEnd;
  logic                    frameWrap;
  logic                    inBlank;

  logic [4*NUM_DIGITS-1:0] actDigits;
  logic [NUM_DIGITS-1:0]   actDp;
  logic [NUM_DIGITS-1:0]   actBlank;
  logic [4*NUM_DIGITS-1:0] shDigits;
  logic [NUM_DIGITS-1:0]   shDp;
  logic [NUM_DIGITS-1:0]   shBlank;
  logic                    pending;

  logic [3:0]              curNib;
  logic                    curDp;
  logic                    curBlank;
  logic                    suppress;
  logic                    allZero;
  logic [NUM_DIGITS-1:0]   anodeNext;

  function automatic logic [6:0] hexSeg(input logic [3:0] nib);
    case (nib)
      4'h0: hexSeg = 7'h40;
      4'h1: hexSeg = 7'h79;
      4'h2: hexSeg = 7'h24;
      4'h3: hexSeg = 7'h30;
      4'h4: hexSeg = 7'h19;
      4'h5: hexSeg = 7'h12;
      4'h6: hexSeg = 7'h02;
      4'h7: hexSeg = 7'h78;
      4'h8: hexSeg = 7'h00;
      4'h9: hexSeg = 7'h10;
      4'hA: hexSeg = 7'h08;
      4'hB: hexSeg = 7'h03;
      4'hC: hexSeg = 7'h46;
      4'hD: hexSeg = 7'h21;
      4'hE: hexSeg = 7'h06;
      default: hexSeg = 7'h0E;
    endcase
  endfunction

  assign slotEnd   = (cnt == CNT_LAST);
  assign frameWrap = slotEnd && (idx == IDX_LAST);

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      cnt <= '0;
      idx <= '0;
    end else if (slotEnd) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load landing on the wrap edge refills the shadow after the old shadow is applied,
  // so pending stays set for the following frame.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      actDigits <= '0;
      actDp     <= '0;
      actBlank  <= '1;
      shDigits  <= '0;
      shDp      <= '0;
      shBlank   <= '1;
      pending   <= 1'b0;
    end else begin
      if (frameWrap && pending) begin
        actDigits <= shDigits;
        actDp     <= shDp;
        actBlank  <= shBlank;
        pending   <= 1'b0;
      end
      if (loadIn) begin
        shDigits <= digitsIn;
        shDp     <= dpIn;
        shBlank  <= blankIn;
        pending  <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down so allZero covers the digit and all above it.
  always_comb begin
    curNib   = '0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    suppress = 1'b0;
    allZero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allZero = allZero && (actDigits[4*i +: 4] == 4'h0);
      if (idx == IDXW'(i)) begin
        curNib   = actDigits[4*i +: 4];
        curDp    = actDp[i];
        curBlank = actBlank[i];
        suppress = lzsIn && allZero && (i != 0);
      end
    end
  end

  generate
    if (BLANK_CYCLES > 0) begin : genBlank
      assign inBlank = (cnt < BLANK_END);
    end else begin : genNoBlank
      assign inBlank = 1'b0;
    end
  endgenerate

  assign anodeNext = inBlank ? '1 : ~(NUM_DIGITS'(1) << idx);

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      segOut     <= 7'h7F;
      decimalOut <= 1'b1;
      anodeOut   <= '1;
      frameOut   <= 1'b0;
    end else begin
      segOut     <= (curBlank || suppress) ? 7'h7F : hexSeg(curNib);
      decimalOut <= curBlank ? 1'b1 : ~curDp;
      anodeOut   <= anodeNext;
      frameOut   <= (cnt == '0) && (idx == '0);
    end
  end

  assign pendingOut = pending;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: a frame-position reference model predicts each
// cycle's outputs and a negedge monitor compares them against the DUT.
module tb_seg_display_mux;

  localparam int ND     = 4;
  localparam int RDIV   = 4;
  localparam int BLANKC = 1;
  localparam int FRAME  = ND * RDIV;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] anode;
    logic       frame;
    logic       pending;
  } expT;

  localparam expT RESET_EXP = '{seg: 7'h7F, dp: 1'b1, anode: 4'hF, frame: 1'b0, pending: 1'b0};

  logic        clkIn;
  logic        rstNIn;
  logic        loadIn;
  logic [15:0] digitsIn;
  logic [3:0]  dpIn;
  logic [3:0]  blankIn;
  logic        lzsIn;
  logic [6:0]  segOut;
  logic        decimalOut;
  logic [3:0]  anodeOut;
  logic        frameOut;
  logic        pendingOut;

  int compared;
  int mismatched;

  expT expQ[$];

  // Reference model: position within the frame plus displayed/shadow data sets.
  int          mPos;
  logic [15:0] mActD;
  logic [3:0]  mActDp;
  logic [3:0]  mActBl;
  logic [15:0] mShD;
  logic [3:0]  mShDp;
  logic [3:0]  mShBl;
  bit          mPend;

  seg_display_mux #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RDIV),
    .BLANK_CYCLES(BLANKC)
  ) dut (
    .clkIn(clkIn),
    .rstNIn(rstNIn),
    .loadIn(loadIn),
    .digitsIn(digitsIn),
    .dpIn(dpIn),
    .blankIn(blankIn),
    .lzsIn(lzsIn),
    .segOut(segOut),
    .decimalOut(decimalOut),
    .anodeOut(anodeOut),
    .frameOut(frameOut),
    .pendingOut(pendingOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  function automatic logic [6:0] refSeg(input logic [3:0] n);
    case (n)
      4'h0: refSeg = 7'h40;  4'h1: refSeg = 7'h79;  4'h2: refSeg = 7'h24;  4'h3: refSeg = 7'h30;
      4'h4: refSeg = 7'h19;  4'h5: refSeg = 7'h12;  4'h6: refSeg = 7'h02;  4'h7: refSeg = 7'h78;
      4'h8: refSeg = 7'h00;  4'h9: refSeg = 7'h10;  4'hA: refSeg = 7'h08;  4'hB: refSeg = 7'h03;
      4'hC: refSeg = 7'h46;  4'hD: refSeg = 7'h21;  4'hE: refSeg = 7'h06;  default: refSeg = 7'h0E;
    endcase
  endfunction

  task automatic modelReset();
    mPos   = 0;
    mActD  = '0;  mActDp = '0;  mActBl = '1;
    mShD   = '0;  mShDp  = '0;  mShBl  = '1;
    mPend  = 1'b0;
  endtask

  // Predicts outputs after the edge just taken, from the pre-edge model state and inputs.
  task automatic modelStep();
    expT         e;
    int          dIdx;
    int          dCnt;
    logic [3:0]  one;
    logic [15:0] higher;
    one    = 4'b0001;
    dIdx   = mPos / RDIV;
    dCnt   = mPos % RDIV;
    higher = mActD >> (4 * dIdx);
    e.anode = (dCnt < BLANKC) ? 4'hF : ~(one << dIdx);
    e.frame = (mPos == 0);
    if (mActBl[dIdx]) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end else begin
      e.dp  = ~mActDp[dIdx];
      e.seg = (lzsIn && dIdx > 0 && higher == 16'h0) ? 7'h7F : refSeg(mActD[4*dIdx +: 4]);
    end
    if (mPos == FRAME - 1 && mPend) begin
      mActD  = mShD;  mActDp = mShDp;  mActBl = mShBl;
      mPend  = 1'b0;
    end
    if (loadIn) begin
      mShD  = digitsIn;  mShDp = dpIn;  mShBl = blankIn;
      mPend = 1'b1;
    end
    e.pending = mPend;
    expQ.push_back(e);
    mPos = (mPos + 1) % FRAME;
  endtask

  task automatic applyStimulus(input bit ld, input logic [15:0] d, input logic [3:0] dp,
                               input logic [3:0] bl);
    loadIn   = ld;
    digitsIn = d;
    dpIn     = dp;
    blankIn  = bl;
    @(posedge clkIn);
    #1;
    modelStep();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic runUntilPos(input int p);
    while (mPos != p) idle(1);
  endtask

  task automatic resetPulse();
    #1;
    rstNIn = 1'b0;
    loadIn = 1'b0;
    modelReset();
    repeat (2) @(negedge clkIn);
    #2;
    rstNIn = 1'b1;
  endtask

  task automatic checkOutput(input string name, input expT e);
    expT act;
    act = {segOut, decimalOut, anodeOut, frameOut, pendingOut};
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL %s t=%0t: got seg=%h dp=%b an=%b frame=%b pend=%b, expected seg=%h dp=%b an=%b frame=%b pend=%b",
               name, $time, act.seg, act.dp, act.anode, act.frame, act.pending,
               e.seg, e.dp, e.anode, e.frame, e.pending);
    end
  endtask

  // Monitor: reset values while reset is held, otherwise one prediction per cycle.
  initial begin
    expT e;
    compared   = 0;
    mismatched = 0;
    forever begin
      @(negedge clkIn);
      if (!rstNIn) begin
        checkOutput("reset", RESET_EXP);
        expQ.delete();
      end else if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("scan", e);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstNIn   = 1'b0;
    loadIn   = 1'b0;
    digitsIn = '0;
    dpIn     = '0;
    blankIn  = '0;
    lzsIn    = 1'b0;
    modelReset();
    repeat (2) @(negedge clkIn);
    #2;
    rstNIn = 1'b1;

    $display("[TB] reset and idle scan");
    idle(40);
    resetPulse();
    idle(20);

    $display("[TB] decimal digits");
    applyStimulus(1'b1, 16'h1234, 4'b0100, 4'b0000);
    idle(40);

    $display("[TB] hex digits");
    applyStimulus(1'b1, 16'hABCD, 4'b0000, 4'b0000);
    idle(40);

    $display("[TB] leading-zero suppression");
    lzsIn = 1'b1;
    applyStimulus(1'b1, 16'h0070, 4'b0000, 4'b0000);
    idle(40);
    applyStimulus(1'b1, 16'h0000, 4'b0110, 4'b0000);
    idle(40);
    lzsIn = 1'b0;

    $display("[TB] double buffering");
    runUntilPos(5);
    applyStimulus(1'b1, 16'h1111, 4'b0001, 4'b0000);
    idle(3);
    applyStimulus(1'b1, 16'h2222, 4'b0010, 4'b0000);
    idle(30);
    runUntilPos(FRAME - 1);
    applyStimulus(1'b1, 16'h3333, 4'b1000, 4'b0010);
    idle(40);

    $display("[TB] reset with pending load");
    runUntilPos(6);
    applyStimulus(1'b1, 16'h5555, 4'b1111, 4'b0000);
    idle(2);
    resetPulse();
    idle(40);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      if (i % 23 == 0) lzsIn = 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end

    repeat (2) @(negedge clkIn);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Time-multiplexed driver for a row of NUM_DIGITS common-anode seven-segment digits sharing one segment bus. It is the parametrised successor to the single-digit segment decoder. It adds:
- full hex decode;
- per-digit decimal point and blanking;
- leading-zero suppression;
- a programmable scan rate with anti-ghosting blank time;
- double-buffered display data that is applied only at frame boundaries, so a digit never shows a partial update.

It sits between the numeric/status logic and the board's segment and anode pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 0, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clkIn  in  1  system clock; one clock domain.
- rstNIn  in  1  reset, asynchronous, active-low.
- loadIn  in  1  capture digitsIn/dpIn/blankIn into the shadow registers.
- digitsIn  in  4*NUM_DIGITS  hex nibble per digit; digit 0 (rightmost) in bits [3:0].
- dpIn  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- blankIn  in  NUM_DIGITS  1 = digit fully dark (segments and DP).
- lzsIn  in  1  leading-zero suppression enable; sampled live, not shadowed.
- segOut  out  7  segments, active-low; bit 0 = A … bit 6 = G.
- decimalOut  out  1  decimal point, active-low.
- anodeOut  out  NUM_DIGITS  digit enables, active-low; at most one bit low.
- frameOut  out  1  one-cycle pulse at the start of each frame.
- pendingOut  out  1  shadow data captured but not yet applied.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1.
- At terminal count, `cnt` returns to 0 and digit index `idx` advances, wrapping NUM_DIGITS-1 → 0.
- NUM_DIGITS=1: `idx` stays 0 and every slot end is a wrap.

Double buffering:
- loadIn=1 copies the inputs into the shadow registers and sets pending.
- A repeated load before the boundary overwrites the shadow; only the last load is shown.
- At the wrap edge with pending=1: active ← shadow, pending ← 0.
- If loadIn coincides with that wrap edge: the previous shadow is applied, the new data goes into the shadow, and pending stays 1.

Hex decode (segOut value per nibble 0..F):
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
- 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E

Leading-zero suppression (lzsIn=1):
- Digit i > 0 is suppressed when its active nibble and all higher active nibbles are 0.
- Digit 0 is never suppressed.
- A suppressed digit has segOut=7F; its DP still follows dpIn.

Blanking:
- blankIn bit set → segOut=7F and decimalOut=1 for that digit; its anode still scans.
- Anti-ghost window: while cnt < BLANK_CYCLES, anodeOut is all 1s. Otherwise anodeOut has bit idx low.

## Timing
- segOut, decimalOut, anodeOut and frameOut are registered. Each is computed from the pre-edge `idx`, `cnt` and active registers, so outputs lag internal state by 1 cycle.
- Slot = REFRESH_DIV cycles; frame = NUM_DIGITS*REFRESH_DIV cycles.
- frameOut is high for exactly the one cycle in which outputs first show digit 0 of a new frame.
- Load latency: new data is visible on segOut starting at the frameOut cycle after the next wrap.
- pendingOut rises on the cycle after the load edge and falls on the cycle after the wrap edge that applies the data.

Reset values (rstNIn=0, takes effect immediately with no clock edge):

| State | Reset value |
|---|---|
| segOut | 7F |
| decimalOut | 1 |
| anodeOut | all 1s |
| frameOut | 0 |
| pendingOut | 0 |
| cnt, idx | 0 |
| active and shadow digits | 0 |
| dp | 0 |
| blank | all 1s (dark until first load) |

- Reset mid-frame discards any pending load.
- After release, scanning begins from digit 0 / cnt 0 on the first edge.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.

1. **Reset.** Pulse rstNIn low between clock edges → all outputs take reset values asynchronously. After release, with no load: anodes scan, segOut stays 7F, and frameOut pulses every 16 cycles.
2. **Decimal digits.** Load digitsIn=16'h1234, dpIn=4'b0100, blankIn=0, lzsIn=0 → after the next frameOut:
   - digit0: anodeOut=1110, segOut 19.
   - digit1: segOut 30.
   - digit2: segOut 24, decimalOut=0.
   - digit3: segOut 79.
   - anodeOut=1111 in cycle 0 of every slot.
3. **Hex digits.** Load 16'hAbCd → segOut sequence 21, 46, 03, 08 for digits 0..3.
4. **Leading-zero suppression.** lzsIn=1:
   - Load 16'h0070 → digits 3 and 2 show 7F, digit1 78, digit0 40.
   - Load 16'h0000 → only digit0 shows 40.
5. **Double buffering.** Load 16'h1111 mid-frame, then 16'h2222 before the wrap → 1111 never appears. pendingOut is high from the first load until the wrap, and 2222 appears from frameOut onward. A load on the wrap edge leaves pendingOut=1.
6. **Reset mid-operation.** Assert rstNIn low with pendingOut=1 mid-slot → outputs dark immediately and pendingOut=0. After release, the display stays dark until a new load is applied.
